// File: rtl/subpel_row_filter_if.sv
// Row-fetch / filtered-array bus between input_array_mux, subpel_row_filter and the next stage.
interface subpel_row_filter_if;
   localparam int unsigned NUM_PIXEL = 8;
   localparam int unsigned NUM_ROWS  = NUM_PIXEL + 7;
   localparam int unsigned PIX_W     = 8;
   localparam int unsigned ROW_W     = NUM_ROWS * PIX_W;
   localparam int unsigned ARR_W     = NUM_ROWS * NUM_PIXEL * PIX_W;

   logic             start;
   logic [7:0]       sel;
   logic [ROW_W-1:0] row_in;
   logic [ARR_W-1:0] a_half_array;
   logic [ARR_W-1:0] b_half_array;
   logic [ARR_W-1:0] c_half_array;
   logic             busy;
   logic             done;

   modport master (
      output start, row_in,
      input  sel, a_half_array, b_half_array, c_half_array, busy, done
   );

   modport slave (
      input  start, row_in,
      output sel, a_half_array, b_half_array, c_half_array, busy, done
   );
endinterface

// File: rtl/subpel_row_filter.sv
// Horizontal HEVC luma quarter/half/three-quarter 8-tap filter over the 15 integer rows
// of a block, fetched one row per cycle through a 1-cycle-latency row mux.
module subpel_row_filter (
   input  logic                 clock,
   input  logic                 reset,
   subpel_row_filter_if.slave   bus
);
   localparam int unsigned NUM_PIXEL = 8;
   localparam int unsigned NUM_ROWS  = NUM_PIXEL + 7;
   localparam int unsigned PIX_W     = 8;
   localparam int unsigned SUM_W     = 16;
   localparam int unsigned ROW_CW    = 4;
   localparam int unsigned ARR_W     = NUM_ROWS * NUM_PIXEL * PIX_W;
   localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(NUM_ROWS - 1);

   localparam int COEF_A [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
   localparam int COEF_B [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
   localparam int COEF_C [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t              state_q;
   logic [ROW_CW-1:0]   row_q;
   logic                drain_q;
   logic                busy_q;
   logic                done_q;

   logic                v1_q, v2_q;
   logic [ROW_CW-1:0]   r1_q, r2_q;

   logic signed [SUM_W-1:0] sum_a_d [NUM_PIXEL];
   logic signed [SUM_W-1:0] sum_b_d [NUM_PIXEL];
   logic signed [SUM_W-1:0] sum_c_d [NUM_PIXEL];
   logic signed [SUM_W-1:0] sum_a_q [NUM_PIXEL];
   logic signed [SUM_W-1:0] sum_b_q [NUM_PIXEL];
   logic signed [SUM_W-1:0] sum_c_q [NUM_PIXEL];

   logic [ARR_W-1:0] a_arr_q, b_arr_q, c_arr_q;

   // Sequencer: row counter doubles as the mux select and rests at 0 outside ISSUE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         drain_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_ISSUE;
                  row_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (row_q == ROW_LAST) begin
                  state_q <= S_DRAIN;
                  row_q   <= '0;
                  drain_q <= 1'b0;
               end else begin
                  row_q <= row_q + ROW_CW'(1);
               end
            end
            S_DRAIN: begin
               drain_q <= 1'b1;
               if (drain_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Valid/row-index pipe: v1 = row on row_in, v2 = stage-1 sums held.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         r1_q <= '0;
         r2_q <= '0;
      end else begin
         v1_q <= (state_q == S_ISSUE);
         r1_q <= row_q;
         v2_q <= v1_q;
         r2_q <= r1_q;
      end
   end

   // Stage 1: three 8-tap dot products per output sample.
   always_comb begin
      int acc_a, acc_b, acc_c, pix;
      acc_a = 0;
      acc_b = 0;
      acc_c = 0;
      pix   = 0;
      for (int i = 0; i < int'(NUM_PIXEL); i++) begin
         acc_a = 0;
         acc_b = 0;
         acc_c = 0;
         for (int k = 0; k < 8; k++) begin
            pix   = int'(bus.row_in[PIX_W*(i+k) +: PIX_W]);
            acc_a = acc_a + pix * COEF_A[k];
            acc_b = acc_b + pix * COEF_B[k];
            acc_c = acc_c + pix * COEF_C[k];
         end
         sum_a_d[i] = SUM_W'(acc_a);
         sum_b_d[i] = SUM_W'(acc_b);
         sum_c_d[i] = SUM_W'(acc_c);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_PIXEL); i++) begin
            sum_a_q[i] <= '0;
            sum_b_q[i] <= '0;
            sum_c_q[i] <= '0;
         end
      end else if (v1_q) begin
         for (int i = 0; i < int'(NUM_PIXEL); i++) begin
            sum_a_q[i] <= sum_a_d[i];
            sum_b_q[i] <= sum_b_d[i];
            sum_c_q[i] <= sum_c_d[i];
         end
      end
   end

   // Round by 1/2 LSB, arithmetic shift by 6, saturate to an 8-bit pixel.
   function automatic logic [PIX_W-1:0] round_clip(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W:0] t;
      t = (SUM_W+1)'(s) + 17'sd32;
      t = t >>> 6;
      if (t < 17'sd0)
         return 8'd0;
      else if (t > 17'sd255)
         return 8'd255;
      else
         return t[PIX_W-1:0];
   endfunction

   // Stage 2: only the row tagged by r2 is rewritten; others hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_arr_q <= '0;
         b_arr_q <= '0;
         c_arr_q <= '0;
      end else if (v2_q) begin
         for (int i = 0; i < int'(NUM_PIXEL); i++) begin
            a_arr_q[{r2_q, 3'(i), 3'b000} +: PIX_W] <= round_clip(sum_a_q[i]);
            b_arr_q[{r2_q, 3'(i), 3'b000} +: PIX_W] <= round_clip(sum_b_q[i]);
            c_arr_q[{r2_q, 3'(i), 3'b000} +: PIX_W] <= round_clip(sum_c_q[i]);
         end
      end
   end

   assign bus.sel          = {4'b0000, row_q};
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.a_half_array = a_arr_q;
   assign bus.b_half_array = b_arr_q;
   assign bus.c_half_array = c_arr_q;
endmodule

// File: tb/tb_subpel_row_filter.sv
// Directed bench for subpel_row_filter with a 1-cycle-latency row mux model.
module tb_subpel_row_filter;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   subpel_row_filter_if bus ();
   subpel_row_filter dut (.clock(clock), .reset(reset), .bus(bus));

   logic [119:0] mux_rows [15];

   // Registered mux: row selected in cycle n appears on row_in in cycle n+1.
   always @(posedge clock or posedge reset) begin
      if (reset) bus.row_in <= '0;
      else       bus.row_in <= mux_rows[bus.sel[3:0]];
   end

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string        name;
      logic [119:0] row;
      int           idx;
      int           ea, eb, ec;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sample(input int which, input int r, input int i);
      logic [7:0] v;
      case (which)
         0:       v = bus.a_half_array[(r*8+i)*8 +: 8];
         1:       v = bus.b_half_array[(r*8+i)*8 +: 8];
         default: v = bus.c_half_array[(r*8+i)*8 +: 8];
      endcase
      return int'(v);
   endfunction

   task automatic fill_rows(input logic [119:0] pat);
      for (int k = 0; k < 15; k++) mux_rows[k] = pat;
   endtask

   // Pulse start, return the cycle (1 = first ISSUE cycle) in which done is seen, -1 on timeout.
   task automatic run_block(output int done_cycle);
      int n;
      @(negedge clock); bus.start = 1'b1;
      @(negedge clock); bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 40) begin
         @(negedge clock);
         n++;
      end
      done_cycle = bus.done ? n : -1;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [119:0] flat, step, over, under, ramp;
      int dc;

      flat  = {15{8'd100}};
      step  = {{11{8'hFF}}, {4{8'h00}}};
      over  = {{10{8'h00}}, 8'hFF, 8'hFF, {3{8'h00}}};
      under = {{7{8'h00}}, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
      ramp  = '0;
      for (int j = 0; j < 15; j++) ramp[8*j +: 8] = 8'(10*j);

      tbl[0] = '{"flat_i0",  flat,  0, 100, 100, 100};
      tbl[1] = '{"flat_i7",  flat,  7, 100, 100, 100};
      tbl[2] = '{"step_i0",  step,  0,  52, 128, 203};
      tbl[3] = '{"over_i0",  over,  0, 255, 255, 255};
      tbl[4] = '{"under_i0", under, 0,   0,   0,   0};
      tbl[5] = '{"ramp_i0",  ramp,  0,  32,  35,  38};
      tbl[6] = '{"ramp_i5",  ramp,  5,  82,  85,  88};

      // Reset state
      reset     = 1'b1;
      bus.start = 1'b0;
      fill_rows('0);
      repeat (2) @(negedge clock);
      check("rst_sel",  int'(bus.sel), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_arrays", int'(|{bus.a_half_array, bus.b_half_array, bus.c_half_array}), 0);
      reset = 1'b0;
      @(negedge clock);

      // Table-driven filter vectors: every row carries the same pattern
      for (int v = 0; v < 7; v++) begin
         fill_rows(tbl[v].row);
         run_block(dc);
         check({tbl[v].name, "_done_cycle"}, dc, 18);
         for (int r = 0; r < 15; r++) begin
            check($sformatf("%s_a_r%0d", tbl[v].name, r), sample(0, r, tbl[v].idx), tbl[v].ea);
            check($sformatf("%s_b_r%0d", tbl[v].name, r), sample(1, r, tbl[v].idx), tbl[v].eb);
            check($sformatf("%s_c_r%0d", tbl[v].name, r), sample(2, r, tbl[v].idx), tbl[v].ec);
         end
      end

      // Sequencing: row k = 10k, start re-pulsed in cycles 5 and 18 must be ignored
      for (int k = 0; k < 15; k++) mux_rows[k] = {15{8'(10*k)}};
      @(negedge clock); bus.start = 1'b1;
      @(negedge clock); bus.start = 1'b0;
      for (int n = 1; n <= 21; n++) begin
         check($sformatf("seq_sel_c%0d", n),  int'(bus.sel),  (n <= 15) ? n - 1 : 0);
         check($sformatf("seq_busy_c%0d", n), int'(bus.busy), (n <= 18) ? 1 : 0);
         check($sformatf("seq_done_c%0d", n), int'(bus.done), (n == 18) ? 1 : 0);
         bus.start = (n == 5 || n == 18);
         @(negedge clock);
      end
      bus.start = 1'b0;
      for (int r = 0; r < 15; r++)
         check($sformatf("seq_b_r%0d", r), sample(1, r, 3), 10*r);

      // Reset mid-block in cycle 9
      fill_rows({15{8'd77}});
      @(negedge clock); bus.start = 1'b1;
      @(negedge clock); bus.start = 1'b0;
      repeat (8) @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_rst_sel",  int'(bus.sel), 0);
      check("mid_rst_busy", int'(bus.busy), 0);
      check("mid_rst_done", int'(bus.done), 0);
      check("mid_rst_arrays", int'(|{bus.a_half_array, bus.b_half_array, bus.c_half_array}), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("post_rst_idle_busy", int'(bus.busy), 0);
      end
      fill_rows(flat);
      run_block(dc);
      check("post_rst_done_cycle", dc, 18);
      check("post_rst_b_r0",  sample(1, 0, 0), 100);
      check("post_rst_a_r14", sample(0, 14, 7), 100);
      check("post_rst_c_r7",  sample(2, 7, 4), 100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/subpel_row_filter.md
# subpel_row_filter

Horizontal HEVC luma sub-pel filter stage that sits directly downstream of `input_array_mux`. It drives the mux `sel` through the 15 integer rows and consumes the registered 120-bit row the mux returns one cycle later. Each row goes through the three 8-tap HEVC luma filters (quarter `a`, half `b`, three-quarter `c`). The filtered rows accumulate into the 960-bit `a_half_array`, `b_half_array` and `c_half_array` buses consumed by the next stage.

## Interface
- `num_pixel`, 8: output samples per row; input row width is `num_pixel+7` pixels.
- `num_rows`, 15: rows processed per block (`num_pixel+7`).
- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  begin a block; sampled only in IDLE.
- `sel`  out  8  row select to `input_array_mux`.
- `row_in`  in  120  mux output; pixel j = `row_in[8j+7:8j]`, unsigned, j=0..14.
- `a_half_array`  out  960  quarter-pel results; sample (r,i) at `[(r*8+i)*8 +: 8]`.
- `b_half_array`  out  960  half-pel results, same packing.
- `c_half_array`  out  960  three-quarter-pel results, same packing.
- `busy`  out  1  high from ISSUE entry through the DONE cycle.
- `done`  out  1  one-cycle pulse when all 15 rows are written.

## Operation
- FSM has four states.
  - IDLE: waits for `start`.
  - ISSUE: 15 cycles, `sel` = 0..14.
  - DRAIN: 2 cycles.
  - DONE: 1 cycle, `done`=1, then returns to IDLE.
- Row counter is 4 bits, 0..14, and drives `sel` (zero-extended). It does not wrap: at 14 the FSM moves to DRAIN.
- The valid/row-index shift register tracks three points per row:
  - v0: `sel` issued this cycle.
  - v1: `row_in` holds that row this cycle, because the mux registers its output.
  - v2: stage-1 sums are valid.
- Stage 1 (captured at the end of a v1 cycle) computes, for i=0..7, the 16-bit signed `sum = Σk coef[k]·pixel[i+k]` for k=0..7.
- Coefficients:
  - a = {-1,4,-10,58,17,-5,1,0}
  - b = {-1,4,-11,40,40,-11,4,-1}
  - c = {0,1,-5,17,58,-10,4,-1}
- Stage 2 (end of a v2 cycle) computes `(sum+32)>>>6` as an arithmetic shift, clips it to [0,255], and writes it into row r of each array. Other rows hold their values.
- Arrays are not cleared on `start`. They are overwritten row by row and hold their values after `done` until the next block or `reset`.
- `start` while not in IDLE is ignored.
- `row_in` is ignored whenever v1=0.

## Timing
- Reset values:
  - `sel` = 0
  - `busy` = 0
  - `done` = 0
  - all arrays = 0
  - FSM = IDLE
  - valid pipe cleared
- `start` high at edge E0 → ISSUE. Cycle n (n=1..15, after edge E(n-1)) has `sel` = n-1 and `busy` = 1.
- Row k is expected on `row_in` in cycle k+2 and written to the arrays at edge E(k+3). Row 14 is written at E17.
- `done`=1 in cycle 18 only, with `busy` still 1. IDLE from cycle 19: `busy`=0, `sel`=0.
- Back-to-back blocks: `start` high during the DONE cycle is ignored. `start` is accepted from cycle 19 (earliest E18).
- In IDLE/DRAIN/DONE `sel` = 0.
- Reset asserted mid-block: the FSM, pipe and arrays clear asynchronously, no `done` is emitted, and partial rows are discarded.
- Throughput: one row per cycle; 18 cycles start-to-done.

## Test plan
- Flat input: every `row_in` pixel = 100 → all 120 samples in a, b and c = 100; `done` in cycle 18.
- Step row: pixels 0..3 = 0, 4..14 = 255, all rows → sample (r,0): a = 52, b = 128, c = 203.
- Overshoot clip: pixels 0..7 = {0,0,0,255,255,0,0,0}, rest 0 → b(r,0) = 255, since the raw value 319 is clipped.
- Undershoot clip: pixels 0..7 = {255,255,255,0,0,255,255,255} → b(r,0) = 0, since the raw value -64 is clipped.
- Sequencing: `start` pulse with a mux model that has 1-cycle latency and row k filled with pixel value 10k → `sel` = 0..14 in cycles 1..15; row k of b = 10k; `busy` high cycles 1..18; `start` re-pulsed in cycle 5 and in cycle 18 is ignored.
- Reset mid-op: assert `reset` in cycle 9 → all outputs are 0 in the same cycle; a fresh `start` then completes normally with `done` 18 cycles later.
